// File: rtl/count_display_driver.sv
// Two-digit multiplexed seven-segment driver for a 4-bit counter value (shown as 00-15).
// Samples the count, pulses on change, and snapshots it once per refresh frame.
module count_display_driver #(
    parameter int unsigned REFRESH_DIV = 4,
    parameter bit          BLANK_LZ    = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] count,
    output logic [6:0] seg,
    output logic [1:0] an,
    output logic       chg
);

    localparam int unsigned DIV_W    = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_ZERO  = 7'h40;
    localparam logic [6:0] SEG_ONE   = 7'h79;

    logic [3:0]       cnt_q, disp_q, disp_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             dsel_q, dsel_d;
    logic [6:0]       seg_q, seg_d;
    logic [1:0]       an_q, an_d;
    logic             chg_q, chg_d;
    logic             tens_c;
    logic [3:0]       ones_c;

    // Active-low {g,f,e,d,c,b,a} patterns for a single decimal digit
    function automatic logic [6:0] dec(input logic [3:0] d);
        case (d)
            4'd0:    dec = 7'h40;
            4'd1:    dec = 7'h79;
            4'd2:    dec = 7'h24;
            4'd3:    dec = 7'h30;
            4'd4:    dec = 7'h19;
            4'd5:    dec = 7'h12;
            4'd6:    dec = 7'h02;
            4'd7:    dec = 7'h78;
            4'd8:    dec = 7'h00;
            4'd9:    dec = 7'h10;
            default: dec = 7'h7F;
        endcase
    endfunction

    always_comb begin
        tens_c = (disp_q >= 4'd10);
        ones_c = tens_c ? (disp_q - 4'd10) : disp_q;

        chg_d  = (count != cnt_q);
        div_d  = div_q + DIV_W'(1);
        dsel_d = dsel_q;
        disp_d = disp_q;
        if (div_q == DIV_LAST) begin
            div_d  = '0;
            dsel_d = ~dsel_q;
            // End of the tens slot closes the frame: take a fresh snapshot
            if (dsel_q) disp_d = cnt_q;
        end

        seg_d = SEG_BLANK;
        an_d  = 2'b11;
        if (!dsel_q) begin
            an_d  = 2'b10;
            seg_d = dec(ones_c);
        end else if (tens_c) begin
            an_d  = 2'b01;
            seg_d = SEG_ONE;
        end else if (!BLANK_LZ) begin
            an_d  = 2'b01;
            seg_d = SEG_ZERO;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            disp_q <= '0;
            div_q  <= '0;
            dsel_q <= 1'b0;
            seg_q  <= SEG_BLANK;
            an_q   <= 2'b11;
            chg_q  <= 1'b0;
        end else begin
            cnt_q  <= count;
            disp_q <= disp_d;
            div_q  <= div_d;
            dsel_q <= dsel_d;
            seg_q  <= seg_d;
            an_q   <= an_d;
            chg_q  <= chg_d;
        end
    end

    assign seg = seg_q;
    assign an  = an_q;
    assign chg = chg_q;

endmodule

// File: tb/tb_count_display_driver.sv
// Directed bench for count_display_driver: one instance blanks the leading zero, one shows it.
// Expected outputs are queued as stimulus is driven and popped after each clock edge.
module tb_count_display_driver;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] count;
    logic [6:0] seg, seg_lz;
    logic [1:0] an, an_lz;
    logic       chg, chg_lz;

    count_display_driver #(.REFRESH_DIV(4), .BLANK_LZ(1'b1)) dut (
        .clk(clk), .rst(rst), .count(count), .seg(seg), .an(an), .chg(chg)
    );
    count_display_driver #(.REFRESH_DIV(4), .BLANK_LZ(1'b0)) dut_lz (
        .clk(clk), .rst(rst), .count(count), .seg(seg_lz), .an(an_lz), .chg(chg_lz)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic [6:0] seg;
        logic [1:0] an;
        logic [6:0] seg_lz;
        logic [1:0] an_lz;
        logic       chg;
    } exp_t;

    exp_t       sb[$];
    int         n_tests = 0;
    int         n_fail  = 0;
    logic [3:0] last_cnt;
    logic [6:0] dec_tab [10];

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Expected display for a shown value in a given slot
    task automatic push_exp(input string tag, input int v, input bit tens_slot, input bit c);
        exp_t e;
        e.tag = tag;
        e.chg = c;
        if (!tens_slot) begin
            e.an = 2'b10; e.seg = dec_tab[(v >= 10) ? v - 10 : v];
            e.an_lz = e.an; e.seg_lz = e.seg;
        end else if (v >= 10) begin
            e.an = 2'b01; e.seg = 7'h79; e.an_lz = 2'b01; e.seg_lz = 7'h79;
        end else begin
            e.an = 2'b11; e.seg = 7'h7F; e.an_lz = 2'b01; e.seg_lz = 7'h40;
        end
        sb.push_back(e);
    endtask

    task automatic push_reset(input string tag);
        exp_t e;
        e.tag = tag; e.chg = 1'b0;
        e.an = 2'b11; e.seg = 7'h7F; e.an_lz = 2'b11; e.seg_lz = 7'h7F;
        sb.push_back(e);
    endtask

    task automatic pop_check();
        exp_t e;
        if (sb.size() == 0) begin
            n_tests++; n_fail++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
            return;
        end
        e = sb.pop_front();
        chk({e.tag, "_seg"},    {1'b0, seg},    {1'b0, e.seg});
        chk({e.tag, "_an"},     {6'b0, an},     {6'b0, e.an});
        chk({e.tag, "_seglz"},  {1'b0, seg_lz}, {1'b0, e.seg_lz});
        chk({e.tag, "_anlz"},   {6'b0, an_lz},  {6'b0, e.an_lz});
        chk({e.tag, "_chg"},    {7'b0, chg},    {7'b0, e.chg});
        chk({e.tag, "_chglz"},  {7'b0, chg_lz}, {7'b0, e.chg});
    endtask

    // Drive one edge; c is the count presented to that edge
    task automatic step(input string tag, input logic [3:0] c, input int shown, input int e_idx);
        count = c;
        push_exp(tag, shown, (e_idx >= 5), (c != last_cnt));
        last_cnt = c;
        @(posedge clk); #1;
        pop_check();
    endtask

    // One refresh frame (edges 1..n); count switches to c_late from edge late_edge on
    task automatic frame(input string tag, input logic [3:0] c_early, input logic [3:0] c_late,
                         input int late_edge, input int shown, input int n_edges);
        for (int e = 1; e <= n_edges; e++)
            step(tag, (e >= late_edge) ? c_late : c_early, shown, e);
    endtask

    initial begin
        dec_tab[0] = 7'h40; dec_tab[1] = 7'h79; dec_tab[2] = 7'h24; dec_tab[3] = 7'h30;
        dec_tab[4] = 7'h19; dec_tab[5] = 7'h12; dec_tab[6] = 7'h02; dec_tab[7] = 7'h78;
        dec_tab[8] = 7'h00; dec_tab[9] = 7'h10;

        rst = 1'b1; count = 4'd7; last_cnt = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        push_reset("reset_init");
        pop_check();
        rst = 1'b0;

        frame("frame0_zero",   4'd7,  4'd7,  9, 0, 8);
        frame("single7",       4'd7,  4'd7,  9, 7, 8);
        frame("load12",        4'd12, 4'd12, 9, 7, 8);
        frame("notear12",      4'd12, 4'd3,  7, 12, 8);
        frame("show3",         4'd3,  4'd3,  9, 3, 8);
        frame("load15",        4'd15, 4'd15, 9, 3, 8);
        frame("show15",        4'd15, 4'd15, 9, 15, 8);
        frame("wrap0",         4'd0,  4'd0,  9, 15, 8);
        frame("show0",         4'd9,  4'd9,  9, 0, 2);

        // Asynchronous reset mid-frame, checked before the next edge
        #2 rst = 1'b1;
        #1;
        push_reset("reset_mid");
        pop_check();
        @(posedge clk); #1;
        push_reset("reset_held");
        pop_check();
        rst = 1'b0;
        last_cnt = 4'd0;

        frame("post_reset",    4'd9,  4'd9,  9, 0, 8);
        frame("show9",         4'd10, 4'd10, 9, 9, 8);
        for (int j = 1; j <= 17; j++)
            frame("freerun", 4'((10 + j) % 16), 4'((10 + j) % 16), 9, (9 + j) % 16, 8);

        if (sb.size() != 0) begin
            n_tests++; n_fail++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/count_display_driver.md
# count_display_driver

Downstream consumer of the 4-bit up counter: takes the counter's `count[3:0]` and drives a two-digit, time-multiplexed, active-low seven-segment display showing the value in decimal (00–15). It registers the incoming count and flags every change. It snapshots the value once per refresh frame so a digit pair never tears. A prescaler alternates the two digit enables.

## Interface
- `REFRESH_DIV`, default 4: clock cycles each digit stays selected. Legal range ≥ 2. Default is sized for simulation; synthesis overrides it.
- `BLANK_LZ`, default 1: 1 = blank the tens digit when it is 0; 0 = show a leading "0".
- `clk`  input  1  system clock, all state on rising edge.
- `rst`  input  1  reset, asynchronous and active-high.
- `count`  input  4  binary value from the up counter, synchronous to `clk`.
- `seg`  output  7  segments {g,f,e,d,c,b,a}, active-low, registered.
- `an`  output  2  digit enables, active-low, registered. `an[0]` = ones digit, `an[1]` = tens digit.
- `chg`  output  1  one-cycle pulse: `count` differed from the previous sampled value.

## Operation
- Reset values (async, take effect immediately):
  - `cnt_q`=0, `disp_q`=0, `div_cnt`=0, `dsel`=0.
  - `seg`=7'h7F, `an`=2'b11, `chg`=0.
- Input stage:
  - `cnt_q` <= `count` every cycle.
  - `chg` <= (`count` != `cnt_q`).
- Prescaler, width clog2(`REFRESH_DIV`):
  - If `div_cnt`==`REFRESH_DIV`-1: `div_cnt`<=0 and `dsel`<=~`dsel`.
  - Otherwise `div_cnt`<=`div_cnt`+1.
- Frame snapshot: on the edge where `div_cnt`==`REFRESH_DIV`-1 and `dsel`==1 (tens slot ending), `disp_q` <= `cnt_q`. At no other time does `disp_q` change.
- Binary to BCD:
  - `tens` = (`disp_q` ≥ 10).
  - `ones` = `disp_q` − 10 when `tens` is set, else `disp_q`.
  - Both are pure functions of `disp_q`.
- Output register, loaded every cycle from the current `dsel`/`disp_q`:
  - `dsel`=0: `an`=2'b10, `seg`=dec(`ones`).
  - `dsel`=1, `tens`=1: `an`=2'b01, `seg`=dec(1)=7'h79.
  - `dsel`=1, `tens`=0, `BLANK_LZ`=1: `an`=2'b11, `seg`=7'h7F.
  - `dsel`=1, `tens`=0, `BLANK_LZ`=0: `an`=2'b01, `seg`=7'h40.
- Decode `dec()`:
  - 0→40, 1→79, 2→24, 3→30, 4→19
  - 5→12, 6→02, 7→78, 8→00, 9→10 (hex)
  - Codes 10–15 are unreachable and map to 7'h7F.
- Exactly one `an` bit is low at any time, except both high in reset and in a blanked tens slot.

## Timing
- `chg` rises one cycle after `count` changes and lasts one cycle per change. A change every cycle gives `chg` high continuously.
- `seg`/`an` lag `dsel` by one cycle (registered outputs).
- Refresh frame = 2·`REFRESH_DIV` cycles. With default 4:
  - `dsel` goes 1 on the 4th edge after reset release and back to 0 on the 8th.
  - The 8th edge loads `disp_q`.
  - The new value appears on `seg` from the 9th edge.
- Display latency from a `count` change is 2 cycles minimum and 2·`REFRESH_DIV`+1 maximum.
- A `count` change mid-frame never alters the digits currently shown. Only the value in `cnt_q` at the frame-end edge is displayed; intermediate values are dropped.
- Counter wrap 15→0 is an ordinary change: `chg` pulses and the next frame shows 00, rendered as " 0" when `BLANK_LZ`=1.
- Reset asserted mid-frame: every register returns to its reset value at once. After release the prescaler restarts from 0 with `dsel`=0, and the display shows 0 until the first frame-end snapshot.

## Test plan
- Reset check: assert `rst` mid-frame with `count`=9. Required: `seg`=7'h7F, `an`=2'b11, `chg`=0 immediately. After release, the first frame shows `an`=10, `seg`=7'h40.
- Single digit: hold `count`=7 from reset, default params. Required:
  - From the 9th edge, ones slot shows `an`=10, `seg`=7'h78.
  - Tens slot shows `an`=11, `seg`=7'h7F.
  - Each slot lasts 4 cycles.
- Two digits: `count`=12. Required:
  - Ones slot: `an`=10, `seg`=7'h24.
  - Tens slot: `an`=01, `seg`=7'h79.
- No tearing: change `count` 12→3 two cycles into the tens slot. Required:
  - The current tens slot still shows 7'h79.
  - `chg` pulses one cycle.
  - The next frame shows ones 7'h30 with tens blanked.
- Wrap and leading zero: drive `count` 15→0 with `BLANK_LZ`=0. Required:
  - Frame shows 7'h12/7'h79, then 7'h40/7'h40 with `an`=01 in the tens slot.
  - `chg` pulses once.
- Free-running: connect to an up counter stepping every 2·`REFRESH_DIV` cycles. Required: `chg` pulses at each step, and displayed values track 0…15…0 with no out-of-range `seg` codes.
